mdu_issue_ctrl: RTL and testbench
=================================

MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: RUN-phase length for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: RUN-phase length for div/divu.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  E-stage holds a candidate MDU instruction.
REQ-006 SHALL have port req_op  input  6  MDU opcode of the E-stage instruction.
REQ-007 SHALL have port req_a  input  32  rs operand.
REQ-008 SHALL have port req_b  input  32  rt operand.
REQ-009 SHALL have port flush  input  1  E-stage instruction is cancelled this cycle.
REQ-010 SHALL have port mdu_start  output  1  one-cycle issue pulse to MDU start.
REQ-011 SHALL have port mdu_op  output  6  registered opcode to MDU MDUop.
REQ-012 SHALL have port mdu_num1  output  32  registered operand to MDU MDU_num1.
REQ-013 SHALL have port mdu_num2  output  32  registered operand to MDU MDU_num2.
REQ-014 SHALL have port busy  output  1  MDU occupied (ISSUE or RUN).
REQ-015 SHALL have port stall  output  1  freeze D/E stages.
REQ-016 SHALL have port done  output  1  final RUN cycle of mult/div.

Function
REQ-017 SHALL encode opcodes as NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8; values 9-63 are invalid.
REQ-018 SHALL implement states IDLE, ISSUE, RUN; busy = (state != IDLE).
REQ-019 SHALL accept a request in IDLE when req_valid=1, req_op in 1..6 and flush=0, registering req_op, req_a and req_b and moving to ISSUE.
REQ-020 SHALL drive mdu_start=1 only in ISSUE, for exactly one cycle per accepted request.
REQ-021 SHALL hold mdu_op, mdu_num1 and mdu_num2 stable from acceptance until the next acceptance.
REQ-022 SHALL, in ISSUE, go to RUN for ops 1-4, loading cnt with MULT_CYCLES-1 (ops 1-2) or DIV_CYCLES-1 (ops 3-4).
REQ-023 SHALL, in ISSUE, return to IDLE for ops 5-6, giving one busy cycle.
REQ-024 SHALL, in RUN, decrement cnt each cycle and go to IDLE when cnt==0, so RUN lasts exactly N cycles and busy lasts N+1 cycles.
REQ-025 SHALL assert done combinationally in RUN when cnt==0.
REQ-026 SHALL compute stall = req_valid & (req_op in 1..8) & busy, combinationally, with no flush gating.
REQ-027 SHALL never accept MFHI, MFLO or invalid opcodes: no start, no state change; mf ops only stall while busy.
REQ-028 SHALL NOT cancel an operation in ISSUE or RUN on flush; flush only blocks acceptance in the same IDLE cycle.
REQ-029 SHALL NOT accept back-to-back requests: an op arriving in the cycle after acceptance sees busy=1 and stalls.
REQ-030 SHALL apply no special handling for a zero divisor: same timing, result left to MDU.
REQ-031 SHALL size cnt to ceil(log2(max(MULT_CYCLES, DIV_CYCLES))) bits, with no wrap below 0.

Reset
REQ-032 SHALL asynchronously force state=IDLE, cnt=0, mdu_op=0, mdu_num1=0, mdu_num2=0 on reset, so mdu_start=0, busy=0, done=0 and stall=0.
REQ-033 SHALL abort an in-flight operation on reset mid-operation, emitting no done; the first acceptance is possible on the first edge after reset deasserts.

Structure
REQ-034 SHALL place the opcode constants, the state enum and the default cycle constants in shared package mdu_pkg, which the MDU also uses.
REQ-035 SHALL keep the latency counter inline with no sub-module; the parent instantiates the MDU beside this block, wiring mdu_* to MDU start/MDUop/MDU_num1/MDU_num2.

Verification
REQ-036 SHALL cover: reset, then MULT a=3 b=5 accepted at edge 0 -> mdu_start=1 in cycle 1; busy for cycles 1-6; done in cycle 6; idle in cycle 7.
REQ-037 SHALL cover: DIVU a=100 b=7, then MFLO presented from cycle 1 -> stall=1 for cycles 1-11, 0 in cycle 12, and no mdu_start for MFLO.
REQ-038 SHALL cover: MTHI a=0xDEADBEEF -> mdu_start pulse with mdu_num1=0xDEADBEEF; busy for exactly 1 cycle.
REQ-039 SHALL cover: MULT with flush=1 on the acceptance cycle -> no start, busy=0; a flush during RUN does not shorten busy.
REQ-040 SHALL cover: reset asserted mid-DIV in RUN with cnt=4 -> all outputs 0 immediately; a new MULT accepted after release with MULT timing.
REQ-041 SHALL cover: req_op=9 with req_valid=1 -> no stall, no start, state unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: opcode encodings, issue FSM states and default latencies shared with the MDU
package mdu_pkg;
  localparam logic [5:0] OP_NONE  = 6'd0;
  localparam logic [5:0] OP_MULT  = 6'd1;
  localparam logic [5:0] OP_MULTU = 6'd2;
  localparam logic [5:0] OP_DIV   = 6'd3;
  localparam logic [5:0] OP_DIVU  = 6'd4;
  localparam logic [5:0] OP_MTHI  = 6'd5;
  localparam logic [5:0] OP_MTLO  = 6'd6;
  localparam logic [5:0] OP_MFHI  = 6'd7;
  localparam logic [5:0] OP_MFLO  = 6'd8;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, RUN} mdu_state_t;
endpackage

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: accepts E-stage MDU ops, issues a start pulse and tracks MDU occupancy
module mdu_issue_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        mdu_start,
  output logic [5:0]  mdu_op,
  output logic [31:0] mdu_num1,
  output logic [31:0] mdu_num2,
  output logic        busy,
  output logic        stall,
  output logic        done
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  mdu_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic accept, mul_op, div_op;
  assign accept    = (state == IDLE) && req_valid && !flush && req_op >= OP_MULT && req_op <= OP_MTLO;
  assign mul_op    = mdu_op == OP_MULT || mdu_op == OP_MULTU;
  assign div_op    = mdu_op == OP_DIV || mdu_op == OP_DIVU;
  assign busy      = state != IDLE;
  assign mdu_start = state == ISSUE;
  assign done      = (state == RUN) && (cnt == '0);
  // mf ops only stall; flush deliberately does not gate the stall
  assign stall     = req_valid && req_op >= OP_MULT && req_op <= OP_MFLO && busy;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE) state_n = accept ? ISSUE : IDLE;
    else if (state == ISSUE) begin
      state_n = (mul_op || div_op) ? RUN : IDLE;
      cnt_n   = mul_op ? CW'(MULT_CYCLES - 1) : div_op ? CW'(DIV_CYCLES - 1) : '0;
    end else if (state == RUN) begin
      state_n = (cnt == '0) ? IDLE : RUN;
      cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
    end else state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mdu_op   <= OP_NONE;
      mdu_num1 <= '0;
      mdu_num2 <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        mdu_op   <= req_op;
        mdu_num1 <= req_a;
        mdu_num2 <= req_b;
      end
    end
  end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: directed per-cycle vector table plus reset-mid-operation sequence
module tb_mdu_issue_ctrl;
  logic clk = 0, reset = 1, req_valid = 0, flush = 0;
  logic [5:0] req_op = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic mdu_start, busy, stall, done;
  logic [5:0] mdu_op;
  logic [31:0] mdu_num1, mdu_num2;
  int tests = 0, fails = 0;
  mdu_issue_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_a(req_a),
    .req_b(req_b), .flush(flush), .mdu_start(mdu_start), .mdu_op(mdu_op),
    .mdu_num1(mdu_num1), .mdu_num2(mdu_num2), .busy(busy), .stall(stall), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, v, f;
    logic [5:0] op;
    logic [31:0] a, b;
    logic [73:0] exp;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic r, v, input logic [5:0] op, input logic [31:0] a, b,
                     input logic f, input logic s, bz, st, d, input logic [5:0] eo,
                     input logic [31:0] e1, e2);
    vec_t x;
    x.r = r; x.v = v; x.op = op; x.a = a; x.b = b; x.f = f;
    x.exp = {s, bz, st, d, eo, e1, e2};
    vq.push_back(x);
  endtask
  task automatic check(input string name, input logic [73:0] got, input logic [73:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  function automatic logic [73:0] outs();
    return {mdu_start, busy, stall, done, mdu_op, mdu_num1, mdu_num2};
  endfunction
  initial begin
    int s_cyc, d_cyc, i_cyc;
    logic [31:0] s_n1;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // MULT 3*5: start c1, busy c1-c6, done c6
    add(0, 1, 1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 3, 5);
    for (int k = 2; k <= 5; k++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 5);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 3, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 5);
    // DIVU 100/7 with MFLO waiting from c1
    add(0, 1, 4, 100, 7, 0, 0, 0, 0, 0, 1, 3, 5);
    add(0, 1, 8, 0, 0, 0, 1, 1, 1, 0, 4, 100, 7);
    for (int k = 2; k <= 10; k++) add(0, 1, 8, 0, 0, 0, 0, 1, 1, 0, 4, 100, 7);
    add(0, 1, 8, 0, 0, 0, 0, 1, 1, 1, 4, 100, 7);
    add(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 4, 100, 7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 100, 7);
    // MTHI: single busy cycle
    add(0, 1, 5, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 4, 100, 7);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5, 32'hDEADBEEF, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    // flush on acceptance cycle blocks the MULT
    add(0, 1, 1, 9, 9, 1, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    // invalid op and MFHI while idle: ignored
    add(0, 1, 9, 1, 2, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    add(0, 1, 9, 1, 2, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    add(0, 1, 7, 1, 2, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    // MULT, back-to-back MTLO stalls, flush during RUN keeps full length
    add(0, 1, 1, 2, 4, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1);
    add(0, 1, 6, 11, 12, 0, 1, 1, 1, 0, 1, 2, 4);
    add(0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 2, 4);
    for (int k = 3; k <= 5; k++) add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 2, 4);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 2, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4);
    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].r; req_valid = vq[i].v; req_op = vq[i].op;
      req_a = vq[i].a; req_b = vq[i].b; flush = vq[i].f;
      #1 check($sformatf("row%0d", i), outs(), vq[i].exp);
    end
    // DIV with zero divisor, reset while cnt==4
    @(negedge clk);
    req_valid = 1; req_op = 3; req_a = 50; req_b = 0; flush = 0;
    @(negedge clk);
    req_valid = 0;
    repeat (6) @(negedge clk);
    req_valid = 1; req_op = 8;
    #1 check("div_run", {busy, stall, done}, 3'b110);
    reset = 1;
    #1 check("async_reset", outs(), '0);
    @(negedge clk);
    reset = 0; req_valid = 1; req_op = 1; req_a = 6; req_b = 7;
    s_cyc = -1; d_cyc = -1; i_cyc = -1; s_n1 = 0;
    for (int c = 1; c <= 20 && i_cyc < 0; c++) begin
      @(negedge clk);
      req_valid = 0;
      #1;
      if (mdu_start && s_cyc < 0) begin s_cyc = c; s_n1 = mdu_num1; end
      if (done && d_cyc < 0) d_cyc = c;
      if (!busy && i_cyc < 0) i_cyc = c;
    end
    check("post_reset_start", 74'(s_cyc), 74'(1));
    check("post_reset_num1", 74'(s_n1), 74'(6));
    check("post_reset_done", 74'(d_cyc), 74'(6));
    check("post_reset_idle", 74'(i_cyc), 74'(7));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
